// File: rtl/mat_mul_sched_pkg.sv
// Shared widths, FSM state type and packing helpers for the shared 2x2 multiplier scheduler.
package mat_mul_pkg;

   localparam int ELEM_W   = 2;
   localparam int RES_W    = 5;
   localparam int OP_W     = 8;
   localparam int RESULT_W = 20;

   // Element order inside an operand word {x22,x21,x12,x11} and a result word {r11,r10,r01,r00}
   localparam int E11 = 0;
   localparam int E12 = 1;
   localparam int E21 = 2;
   localparam int E22 = 3;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      WAIT,
      RESP
   } sched_state_t;

   function automatic int elem_lsb(input int elem);
      return elem * ELEM_W;
   endfunction

   function automatic int res_lsb(input int elem);
      return elem * RES_W;
   endfunction

endpackage

// File: rtl/mat_mul_sched_if.sv
// Bus between the scheduler (master) and the single shared mat_wrapper instance (slave).
interface mat_mul_sched_if;
   import mat_mul_pkg::*;

   logic                mm_load;
   logic [ELEM_W-1:0]   mm_a11, mm_a12, mm_a21, mm_a22;
   logic [ELEM_W-1:0]   mm_b11, mm_b12, mm_b21, mm_b22;
   logic [RESULT_W-1:0] mm_result;
   logic                mm_valid;

   modport master (
      output mm_load,
      output mm_a11, mm_a12, mm_a21, mm_a22,
      output mm_b11, mm_b12, mm_b21, mm_b22,
      input  mm_result,
      input  mm_valid
   );

   modport slave (
      input  mm_load,
      input  mm_a11, mm_a12, mm_a21, mm_a22,
      input  mm_b11, mm_b12, mm_b21, mm_b22,
      output mm_result,
      output mm_valid
   );

endinterface

// File: rtl/mat_mul_sched_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx
);

   logic             found;
   logic [IDX_W-1:0] idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = '0;
      for (int k = 0; k < N; k++) begin
         idx = IDX_W'((int'(ptr) + k) % N);
         if (!found && req[idx]) begin
            found        = 1'b1;
            gnt[idx]     = 1'b1;
            gnt_idx      = idx;
         end
      end
   end

endmodule

// File: rtl/mat_mul_sched.sv
// Round-robin scheduler sharing one mat_wrapper 2x2 multiplier between NUM_REQ requesters.
module mat_mul_sched
   import mat_mul_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int LOAD_CYCLES = 2,
   parameter int TIMEOUT     = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [NUM_REQ*OP_W-1:0] req_op_a,
   input  logic [NUM_REQ*OP_W-1:0] req_op_b,
   output logic [NUM_REQ-1:0]      done,
   output logic [RESULT_W-1:0]     resp_result,
   output logic                    resp_err,
   output logic                    busy,
   mat_mul_sched_if.master         mm
);

   localparam int IDX_W = $clog2(NUM_REQ);

   sched_state_t      state, next_state;
   logic [IDX_W-1:0]  rr_ptr, grant, arb_idx, next_ptr;
   logic [NUM_REQ-1:0] arb_gnt;
   logic [3:0]        load_cnt;
   logic [7:0]        wait_cnt;
   logic              valid_q;
   logic              valid_edge, timed_out, load_last, any_gnt;
   logic [OP_W-1:0]   sel_a, sel_b;

   rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
      .req     (req),
      .ptr     (rr_ptr),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx)
   );

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_idx == IDX_W'(i)) begin
            sel_a = req_op_a[i*OP_W +: OP_W];
            sel_b = req_op_b[i*OP_W +: OP_W];
         end
      end
   end

   // A level still high from an earlier operation has valid_q set, so only a fresh rise counts
   assign valid_edge = mm.mm_valid & ~valid_q;
   assign timed_out  = (wait_cnt == 8'(TIMEOUT));
   assign load_last  = (load_cnt == 4'(LOAD_CYCLES - 1));
   assign any_gnt    = |arb_gnt;
   assign next_ptr   = (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
   assign mm.mm_load = (state == LOAD);
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (any_gnt) next_state = LOAD;
         LOAD:    if (load_last) next_state = WAIT;
         WAIT:    if (valid_edge || timed_out) next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr      <= '0;
         grant       <= '0;
         load_cnt    <= '0;
         wait_cnt    <= '0;
         valid_q     <= 1'b0;
         done        <= '0;
         resp_result <= '0;
         resp_err    <= 1'b0;
         mm.mm_a11   <= '0;
         mm.mm_a12   <= '0;
         mm.mm_a21   <= '0;
         mm.mm_a22   <= '0;
         mm.mm_b11   <= '0;
         mm.mm_b12   <= '0;
         mm.mm_b21   <= '0;
         mm.mm_b22   <= '0;
      end else begin
         valid_q  <= mm.mm_valid;
         done     <= '0;
         resp_err <= 1'b0;
         case (state)
            IDLE: begin
               if (any_gnt) begin
                  grant     <= arb_idx;
                  load_cnt  <= '0;
                  mm.mm_a11 <= sel_a[elem_lsb(E11) +: ELEM_W];
                  mm.mm_a12 <= sel_a[elem_lsb(E12) +: ELEM_W];
                  mm.mm_a21 <= sel_a[elem_lsb(E21) +: ELEM_W];
                  mm.mm_a22 <= sel_a[elem_lsb(E22) +: ELEM_W];
                  mm.mm_b11 <= sel_b[elem_lsb(E11) +: ELEM_W];
                  mm.mm_b12 <= sel_b[elem_lsb(E12) +: ELEM_W];
                  mm.mm_b21 <= sel_b[elem_lsb(E21) +: ELEM_W];
                  mm.mm_b22 <= sel_b[elem_lsb(E22) +: ELEM_W];
               end
            end
            LOAD: begin
               load_cnt <= load_cnt + 4'd1;
               wait_cnt <= '0;
            end
            WAIT: begin
               wait_cnt <= wait_cnt + 8'd1;
               // Edge is tested first so it wins over a timeout on the same cycle
               if (valid_edge) begin
                  resp_result <= mm.mm_result;
                  resp_err    <= 1'b0;
                  done        <= NUM_REQ'(1) << grant;
               end else if (timed_out) begin
                  resp_result <= '0;
                  resp_err    <= 1'b1;
                  done        <= NUM_REQ'(1) << grant;
               end
            end
            RESP: rr_ptr <= next_ptr;
            default: ;
         endcase
      end
   end

endmodule
